// File: rtl/multiple_output_response_checker.sv
// -----------------------------------------------------------------------------
// multiple_output_response_checker
//
// Observation-side checker for the four-input / three-output
// multiple_output_circuit family. A sweep is started with `start`. The checker
// then accepts exactly sixteen handshaked transfers. Each transfer carries the
// applied vector {A,B,C,D} and the captured F_alpha/F_beta/F_gamma.
//
// Transfer number `idx` must carry vector `idx`, with outputs matching bit
// `idx` of the EXP_* truth tables. The block tallies failing vectors and
// records the first failing index. It can also compact every transfer into an
// 8-bit MISR signature.
//
// Optional feature macro: CHECKER_MISR_EN
//   defined   -> `signature` is an 8-bit MISR (x^8+x^4+x^3+x^2+1), seeded 8'hFF
//   undefined -> no MISR logic, `signature` is constant 8'h00
//
// Ports
//   clk              : rising-edge clock
//   rst_n            : asynchronous active-low reset
//   start            : begin a sweep (honoured in IDLE or DONE only)
//   vec_valid        : vector/response fields valid this cycle
//   vec_ready        : checker accepts transfers (registered, high only in RUN)
//   A,B,C,D          : applied vector, A is the MSB
//   F_alpha/beta/gamma : observed unit-under-test outputs
//   busy             : sweep in progress (RUN)
//   done             : sweep complete (DONE)
//   pass             : valid with done, 1 when no vector failed
//   err_count        : number of failing vectors (0..16)
//   first_err_vec    : index of the first failing vector
//   first_err_valid  : first_err_vec holds a captured index
//   signature        : MISR contents (or 8'h00 without the MISR)
// -----------------------------------------------------------------------------
module multiple_output_response_checker #(
    parameter logic [15:0] EXP_ALPHA = 16'h6996,
    parameter logic [15:0] EXP_BETA  = 16'hFF00,
    parameter logic [15:0] EXP_GAMMA = 16'h8888
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       vec_valid,
    output logic       vec_ready,
    input  logic       A,
    input  logic       B,
    input  logic       C,
    input  logic       D,
    input  logic       F_alpha,
    input  logic       F_beta,
    input  logic       F_gamma,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [4:0] err_count,
    output logic [3:0] first_err_vec,
    output logic       first_err_valid,
    output logic [7:0] signature
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0] state_r;
    logic [1:0] state_next_s;
    logic [3:0] idx_r;
    logic [4:0] err_count_r;
    logic [3:0] first_err_vec_r;
    logic       first_err_valid_r;
    logic       pass_r;
    logic       busy_r;
    logic       done_r;
    logic       ready_r;

    logic       xfer_s;
    logic       enter_run_s;
    logic       fail_s;
    logic [4:0] err_next_s;

    // The handshake and the start qualifier are decoded from registered state.
    assign xfer_s      = vec_valid & ready_r;
    assign enter_run_s = start & ((state_r == ST_IDLE) | (state_r == ST_DONE));

    // Judge the current transfer against slot idx, never against the received
    // vector, so that an out-of-order vector is checked against idx's outputs.
    always_comb begin
        fail_s = 1'b0;
        if ({A, B, C, D} != idx_r) begin
            fail_s = 1'b1;
        end else if ((F_alpha != EXP_ALPHA[idx_r]) ||
                     (F_beta  != EXP_BETA[idx_r])  ||
                     (F_gamma != EXP_GAMMA[idx_r])) begin
            fail_s = 1'b1;
        end else begin
            fail_s = 1'b0;
        end
    end

    // The error tally including the current transfer; it feeds both the
    // counter and the pass verdict taken on the final transfer.
    assign err_next_s = err_count_r + {4'd0, fail_s};

    // Sweep sequencing: IDLE/DONE -> RUN on start, RUN -> DONE on the 16th transfer.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (xfer_s && (idx_r == 4'd15)) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_DONE: begin
                if (start) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_DONE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State, status flags and results. The status flags are registered from
    // the next state, so they change on the same edge as the state itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r           <= ST_IDLE;
            busy_r            <= 1'b0;
            done_r            <= 1'b0;
            ready_r           <= 1'b0;
            idx_r             <= 4'd0;
            err_count_r       <= 5'd0;
            first_err_vec_r   <= 4'd0;
            first_err_valid_r <= 1'b0;
            pass_r            <= 1'b0;
        end else begin
            state_r <= state_next_s;
            busy_r  <= (state_next_s == ST_RUN);
            ready_r <= (state_next_s == ST_RUN);
            done_r  <= (state_next_s == ST_DONE);
            if (enter_run_s) begin
                idx_r             <= 4'd0;
                err_count_r       <= 5'd0;
                first_err_vec_r   <= 4'd0;
                first_err_valid_r <= 1'b0;
                pass_r            <= 1'b0;
            end else if (xfer_s) begin
                // idx wraps 15 -> 0 on the same edge that enters DONE.
                idx_r       <= idx_r + 4'd1;
                err_count_r <= err_next_s;
                if (fail_s && !first_err_valid_r) begin
                    first_err_vec_r   <= idx_r;
                    first_err_valid_r <= 1'b1;
                end
                if (idx_r == 4'd15) begin
                    pass_r <= (err_next_s == 5'd0);
                end
            end
        end
    end

`ifdef CHECKER_MISR_EN
    // Advance the MISR by one step: shift with feedback 8'h1D, then fold in data.
    function automatic logic [7:0] misr_step(input logic [7:0] sig, input logic [7:0] data);
        misr_step = ({sig[6:0], 1'b0} ^ (sig[7] ? 8'h1D : 8'h00)) ^ data;
    endfunction

    logic [7:0] signature_r;
    logic [7:0] misr_data_s;

    assign misr_data_s = {1'b0, F_alpha, F_beta, F_gamma, A, B, C, D};

    // The MISR is seeded on sweep entry and compacts every accepted transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            signature_r <= 8'h00;
        end else if (enter_run_s) begin
            signature_r <= 8'hFF;
        end else if (xfer_s) begin
            signature_r <= misr_step(signature_r, misr_data_s);
        end
    end

    assign signature = signature_r;
`else
    assign signature = 8'h00;
`endif

    assign vec_ready       = ready_r;
    assign busy            = busy_r;
    assign done            = done_r;
    assign pass            = pass_r;
    assign err_count       = err_count_r;
    assign first_err_vec   = first_err_vec_r;
    assign first_err_valid = first_err_valid_r;

endmodule
